// File: rtl/panda_pc_if.sv
// Fetch-side signal bundle of the PC controller: pipeline/memory inputs and fetch/flush/exception outputs.
// The master side drives the pipeline inputs; the slave side is the controller.
interface panda_pc_if;
   logic        stall_i;
   logic        ex_valid_i;
   logic        change_flow_i;
   logic [31:0] target_address_i;
   logic        fetch_ready_i;
   logic [31:0] pc_o;
   logic        fetch_req_o;
   logic        flush_if_o;
   logic        flush_id_o;
   logic        exc_misaligned_o;
   logic [31:0] exc_tval_o;

   modport master (
      output stall_i, ex_valid_i, change_flow_i, target_address_i, fetch_ready_i,
      input  pc_o, fetch_req_o, flush_if_o, flush_id_o, exc_misaligned_o, exc_tval_o
   );

   modport slave (
      input  stall_i, ex_valid_i, change_flow_i, target_address_i, fetch_ready_i,
      output pc_o, fetch_req_o, flush_if_o, flush_id_o, exc_misaligned_o, exc_tval_o
   );
endinterface

// File: rtl/panda_pc_controller.sv
// Program counter controller: sequential fetch, jump/branch redirects that survive fetch back-pressure,
// and instruction-address-misaligned detection on taken branch targets.
module panda_pc_controller #(
   parameter logic [31:0] BootAddr = 32'h0000_0000
) (
   input logic       clk_i,
   input logic       rst_i,
   panda_pc_if.slave bus
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      REDIRECT_WAIT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;

   logic active;
   logic flow;
   logic redirect;
   logic misaligned;
   logic accept;

   // Decode of the jump/branch unit report; nothing is honoured during the BOOT cycle.
   always_comb begin
      active     = (state_q != BOOT);
      flow       = active & bus.ex_valid_i & bus.change_flow_i;
      redirect   = flow & ~bus.target_address_i[1];
      misaligned = flow & bus.target_address_i[1];
      accept     = active & bus.fetch_ready_i;
   end

   assign bus.pc_o             = pc_q;
   assign bus.fetch_req_o      = active;
   assign bus.flush_if_o       = redirect | (state_q == REDIRECT_WAIT);
   assign bus.flush_id_o       = redirect | misaligned;
   assign bus.exc_misaligned_o = misaligned;
   assign bus.exc_tval_o       = misaligned ? bus.target_address_i : 32'h0;

   always_comb begin
      // NOTE: every next-state value gets a default first so no path through the case infers a latch.
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (redirect) begin
               if (accept) begin
                  pc_d = bus.target_address_i;
               end else begin
                  tgt_d   = bus.target_address_i;
                  state_d = REDIRECT_WAIT;
               end
            end else if (accept && !bus.stall_i) begin
               pc_d = pc_q + 32'd4;
            end
         end
         REDIRECT_WAIT: begin
            // A newer redirect replaces the pending one, whether or not memory accepts this cycle.
            if (redirect) begin
               if (accept) begin
                  pc_d    = bus.target_address_i;
                  state_d = RUN;
               end else begin
                  tgt_d = bus.target_address_i;
               end
            end else if (accept) begin
               pc_d    = tgt_q;
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   // NOTE: the pending-target register is reset too, so a redirect interrupted by reset leaves nothing behind.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= BOOT;
         pc_q    <= BootAddr;
         tgt_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
      end
   end

endmodule

// File: doc/panda_pc_controller.md
PANDA_PC_CONTROLLER -- requirements
Module: panda_pc_controller

Interface
REQ-001 SHALL have parameter BootAddr, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall_i  input  1  hazard stall; when high, the PC is not advanced sequentially.
REQ-005 SHALL have port ex_valid_i  input  1  the EX-stage instruction is valid.
REQ-006 SHALL have port change_flow_i  input  1  the jump/branch unit reports a taken jump or branch.
REQ-007 SHALL have port target_address_i  input  32  redirect target from the jump/branch unit; bit 0 is always 0.
REQ-008 SHALL have port fetch_ready_i  input  1  instruction memory accepts the current request.
REQ-009 SHALL have port pc_o  output  32  current fetch address.
REQ-010 SHALL have port fetch_req_o  output  1  fetch request valid.
REQ-011 SHALL have port flush_if_o  output  1  squash the IF/ID register.
REQ-012 SHALL have port flush_id_o  output  1  squash the ID/EX register.
REQ-013 SHALL have port exc_misaligned_o  output  1  one-cycle instruction-address-misaligned pulse.
REQ-014 SHALL have port exc_tval_o  output  32  faulting target; valid while exc_misaligned_o is high.

Function
REQ-015 SHALL implement states BOOT, RUN and REDIRECT_WAIT.
REQ-016 In BOOT: fetch_req_o=0 and flush outputs are 0; the next state is RUN unconditionally.
REQ-017 In RUN and REDIRECT_WAIT, fetch_req_o SHALL be 1. A request is accepted when fetch_req_o and fetch_ready_i are both high.
REQ-018 Redirect condition: redirect = ex_valid_i & change_flow_i & ~target_address_i[1], evaluated only in RUN or REDIRECT_WAIT.
REQ-019 Misaligned condition: ex_valid_i & change_flow_i & target_address_i[1].
  - Asserts exc_misaligned_o and flush_id_o combinationally that cycle.
  - exc_tval_o = target_address_i.
  - No redirect is performed; the PC follows the sequential rules.
REQ-020 While redirect is high, flush_if_o and flush_id_o SHALL be 1 combinationally in the same cycle.
  - Redirect has priority over stall_i.
REQ-021 RUN, redirect and accept: pc_o becomes target_address_i on the next edge; state stays RUN.
REQ-022 RUN, redirect and no accept: pc_o is held unchanged.
  - The target is latched into an internal register.
  - The next state is REDIRECT_WAIT.
REQ-023 In REDIRECT_WAIT, pc_o SHALL remain stable and flush_if_o SHALL be 1 every cycle.
  - On accept, pc_o becomes the latched target and the next state is RUN.
REQ-024 In REDIRECT_WAIT, a new redirect SHALL overwrite the latched target (latest wins).
  - If the new redirect coincides with accept, pc_o becomes the new target_address_i.
REQ-025 RUN, no redirect, accept and ~stall_i: pc_o <= pc_o + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-026 RUN, no redirect, and either no accept or stall_i: pc_o is held.
REQ-027 exc_tval_o SHALL be 0 whenever exc_misaligned_o is low.
REQ-028 Outputs other than pc_o SHALL carry no registered glitch state beyond the FSM; the flush and exception outputs are combinational from inputs and state.

Reset
REQ-029 While rst_i is high, asynchronously:
  - state = BOOT, pc_o = BootAddr, latched target = 0;
  - fetch_req_o, flush_if_o, flush_id_o and exc_misaligned_o = 0;
  - exc_tval_o = 0.
REQ-030 Reset asserted in REDIRECT_WAIT SHALL discard the pending target; after deassertion, fetch restarts at BootAddr following one BOOT cycle.

Verification
REQ-031 Release reset with BootAddr=32'h8000_0000 and fetch_ready_i=1 -> cycle 1: fetch_req_o=0; then pc_o = 8000_0000, 8000_0004, 8000_0008.
REQ-032 RUN, pc_o=0x100, ex_valid_i=1, change_flow_i=1, target=0x200, fetch_ready_i=1, stall_i=1 -> flush_if_o=flush_id_o=1 that cycle; next pc_o=0x200.
REQ-033 Redirect to 0x300 with fetch_ready_i=0 for 3 cycles -> pc_o held at old value and flush_if_o=1 for 3 cycles; accept -> next pc_o=0x300, state RUN.
REQ-034 In REDIRECT_WAIT (latched 0x300), second redirect to 0x400 then accept -> pc_o=0x400.
REQ-035 Taken branch to 0x102 -> exc_misaligned_o=1, exc_tval_o=0x102, flush_id_o=1, flush_if_o=0; pc_o advances by 4 if accepted and not stalled.
REQ-036 pc_o=32'hFFFF_FFFC, accept, no stall -> pc_o=0; assert rst_i mid REDIRECT_WAIT -> pc_o=BootAddr immediately, fetch_req_o=0.
